// File: rtl/alu_pkg.sv
// Shared opcode encoding, widths and saturation limits for the 6-bit ALU.
package alu_pkg;

  localparam int ALU_W   = 6;
  localparam int ALU_OPW = 4;

  localparam logic [ALU_W-1:0] SAT_MAX = {1'b0, {(ALU_W-1){1'b1}}};
  localparam logic [ALU_W-1:0] SAT_MIN = {1'b1, {(ALU_W-1){1'b0}}};

  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SAR  = 4'd8,
    OP_ROL  = 4'd9,
    OP_ROR  = 4'd10,
    OP_INC  = 4'd11,
    OP_DEC  = 4'd12,
    OP_NEG  = 4'd13,
    OP_MUL  = 4'd14,
    OP_PASS = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel unit for SHL/SHR/SAR/ROL/ROR; also returns the last bit shifted out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] x,
  input  logic [2:0]   amt,
  input  alu_op_e      op,
  output logic [W-1:0] res,
  output logic         out_bit
);

  logic [W:0]        shl_ext;
  logic [W:0]        shr_ext;
  logic signed [W:0] sar_ext;
  logic [2:0]        rot_amt;

  // One guard bit beyond the data catches the final bit shifted out, even past W.
  assign shl_ext = {1'b0, x} << amt;
  assign shr_ext = {x, 1'b0} >> amt;
  assign sar_ext = $signed({x, 1'b0}) >>> amt;
  assign rot_amt = 3'({29'd0, amt} % W);

  always_comb begin
    res     = '0;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        res     = shl_ext[W-1:0];
        out_bit = shl_ext[W];
      end
      OP_SHR: begin
        res     = shr_ext[W:1];
        out_bit = shr_ext[0];
      end
      OP_SAR: begin
        res     = sar_ext[W:1];
        out_bit = sar_ext[0];
      end
      OP_ROL: res = (x << rot_amt) | (x >> (W - int'(rot_amt)));
      OP_ROR: res = (x >> rot_amt) | (x << (W - int'(rot_amt)));
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered two's-complement ALU producing wrapped and saturated results plus flags.
// Define ALU_MUL_EN to enable the signed multiply on op 14.
module alu
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic [OPW-1:0] op,
  output logic [W-1:0]   z,
  output logic [W-1:0]   zNoRing,
  output logic           IOF,
  output logic           BAF,
  output logic           ZF
);

  localparam logic [W-1:0] SAT_HI = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_LO = {1'b1, {(W-1){1'b0}}};

  alu_op_e      op_e;
  logic [W-1:0] arith_a, arith_b;
  logic         arith_sub;
  logic [W:0]   add_full, sub_full;
  logic [W-1:0] shf_res;
  logic         shf_bit;
  logic [W-1:0] z_n, sat_n;
  logic         iof_n, baf_n;

  assign op_e = alu_op_e'(op);

  always_comb begin
    arith_a   = x;
    arith_b   = y;
    arith_sub = 1'b0;
    case (op_e)
      OP_SUB: arith_sub = 1'b1;
      OP_INC: arith_b   = W'(1);
      OP_DEC: begin
        arith_b   = W'(1);
        arith_sub = 1'b1;
      end
      OP_NEG: begin
        arith_a   = '0;
        arith_b   = x;
        arith_sub = 1'b1;
      end
      default: ;
    endcase
  end

  // Top bit of each W+1 result is the carry (add) or borrow (sub).
  assign add_full = {1'b0, arith_a} + {1'b0, arith_b};
  assign sub_full = {1'b0, arith_a} - {1'b0, arith_b};

  alu_shifter #(.W(W)) u_shifter (
    .x       (x),
    .amt     (y[2:0]),
    .op      (op_e),
    .res     (shf_res),
    .out_bit (shf_bit)
  );

`ifdef ALU_MUL_EN
  logic signed [2*W-1:0] mul_prod;
  logic [W-1:0]          mul_uhi;
  logic                  mul_ovf;

  assign mul_prod = $signed(x) * $signed(y);
  assign mul_uhi  = W'(({{W{1'b0}}, x} * {{W{1'b0}}, y}) >> W);
  assign mul_ovf  = (mul_prod[2*W-1:W-1] != '0) && (mul_prod[2*W-1:W-1] != '1);
`endif

  always_comb begin
    z_n   = '0;
    iof_n = 1'b0;
    baf_n = 1'b0;
    sat_n = '0;
    case (op_e)
      OP_ADD, OP_INC: begin
        z_n   = add_full[W-1:0];
        baf_n = add_full[W];
        iof_n = (arith_a[W-1] == arith_b[W-1]) && (z_n[W-1] != arith_a[W-1]);
      end
      OP_SUB, OP_DEC, OP_NEG: begin
        z_n   = sub_full[W-1:0];
        baf_n = sub_full[W];
        iof_n = (arith_a[W-1] != arith_b[W-1]) && (z_n[W-1] != arith_a[W-1]);
      end
      OP_AND:  z_n = x & y;
      OP_OR:   z_n = x | y;
      OP_XOR:  z_n = x ^ y;
      OP_NOT:  z_n = ~x;
      OP_SHL, OP_SHR, OP_SAR: begin
        z_n   = shf_res;
        baf_n = shf_bit;
      end
      OP_ROL, OP_ROR: z_n = shf_res;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        z_n   = mul_prod[W-1:0];
        baf_n = |mul_uhi;
        iof_n = mul_ovf;
      end
`endif
      OP_PASS: z_n = y;
      default: ;
    endcase

    // On overflow the true result has the sign of the minuend / first addend.
    sat_n = z_n;
    if (iof_n) begin
`ifdef ALU_MUL_EN
      if (op_e == OP_MUL) sat_n = mul_prod[2*W-1] ? SAT_LO : SAT_HI;
      else                sat_n = arith_a[W-1]    ? SAT_LO : SAT_HI;
`else
      sat_n = arith_a[W-1] ? SAT_LO : SAT_HI;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z       <= '0;
      zNoRing <= '0;
      IOF     <= 1'b0;
      BAF     <= 1'b0;
      ZF      <= 1'b0;
    end else begin
      z       <= z_n;
      zNoRing <= sat_n;
      IOF     <= iof_n;
      BAF     <= baf_n;
      ZF      <= (z_n == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus random vectors against an integer model.
module tb_alu;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [3:0]   op = '0;
  logic [W-1:0] z, zNoRing;
  logic         IOF, BAF, ZF;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int z;
    int sat;
    int iof;
    int baf;
    int zf;
  } exp_t;

  alu dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .y       (y),
    .op      (op),
    .z       (z),
    .zNoRing (zNoRing),
    .IOF     (IOF),
    .BAF     (BAF),
    .ZF      (ZF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    vec_cnt++;
    if (got != want) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int to_signed(input int u);
    return (u >= 32) ? u - 64 : u;
  endfunction

  // Reference: evaluate the true mathematical result in integers, then wrap / clamp.
  function automatic exp_t model(input int ux, input int uy, input int opc);
    exp_t e;
    int sx, sy, s, r, full;
    bit arith;
    sx = to_signed(ux);
    sy = to_signed(uy);
    s  = uy % 8;
    r  = s % W;
    full = 0;
    arith = 0;
    e.z = 0; e.iof = 0; e.baf = 0;
    case (opc)
      0:  begin full = sx + sy; arith = 1; e.baf = int'((ux + uy) > 63); end
      1:  begin full = sx - sy; arith = 1; e.baf = int'(ux < uy); end
      2:  e.z = ux & uy;
      3:  e.z = ux | uy;
      4:  e.z = ux ^ uy;
      5:  e.z = 63 - ux;
      6:  begin e.z = (ux << s) & 63; e.baf = (s == 0) ? 0 : ((ux << s) >> 6) & 1; end
      7:  begin e.z = ux >> s; e.baf = (s == 0) ? 0 : (ux >> (s - 1)) & 1; end
      8:  begin e.z = (sx >>> s) & 63; e.baf = (s == 0) ? 0 : (sx >>> (s - 1)) & 1; end
      9:  e.z = ((ux << r) | (ux >> (W - r))) & 63;
      10: e.z = ((ux >> r) | (ux << (W - r))) & 63;
      11: begin full = sx + 1; arith = 1; e.baf = int'((ux + 1) > 63); end
      12: begin full = sx - 1; arith = 1; e.baf = int'(ux < 1); end
      13: begin full = -sx; arith = 1; e.baf = int'(ux > 0); end
`ifdef ALU_MUL_EN
      14: begin full = sx * sy; arith = 1; e.baf = int'((ux * uy) > 63); end
`endif
      15: e.z = uy;
      default: e.z = 0;
    endcase
    if (arith) begin
      e.z   = full & 63;
      e.iof = int'(full > 31 || full < -32);
      e.sat = (full > 31) ? 31 : (full < -32) ? 32 : (full & 63);
    end else begin
      e.sat = e.z;
    end
    e.zf = int'(e.z == 0);
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".z"},   int'(z),       e.z);
    check({tag, ".sat"}, int'(zNoRing), e.sat);
    check({tag, ".iof"}, int'(IOF),     e.iof);
    check({tag, ".baf"}, int'(BAF),     e.baf);
    check({tag, ".zf"},  int'(ZF),      e.zf);
  endtask

  task automatic run(input string tag, input int ax, input int ay, input int aop);
    x  = W'(ax);
    y  = W'(ay);
    op = 4'(aop);
    @(posedge clk);
    #1;
    check_all(tag, model(ax & 63, ay & 63, aop));
  endtask

  task automatic check_zero(input string tag);
    exp_t e;
    e.z = 0; e.sat = 0; e.iof = 0; e.baf = 0; e.zf = 0;
    check_all(tag, e);
  endtask

  initial begin
    // Reset held with live inputs, then first result one edge after release.
    rst = 1'b1; x = 6'd5; y = 6'd3; op = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.z", int'(z), 8);
    check_all("post_rst", model(5, 3, 0));

    run("add_ovf", 31, 1, 0);
    check("add_ovf.z_lit", int'(z), 32);
    check("add_ovf.sat_lit", int'(zNoRing), 31);
    run("add_neg_ovf", 32, 63, 0);
    check("add_neg_ovf.sat_lit", int'(zNoRing), 32);
    run("sub_zero", 0, 0, 1);
    check("sub_zero.zf_lit", int'(ZF), 1);
    run("sub_borrow", 0, 1, 1);
    check("sub_borrow.baf_lit", int'(BAF), 1);
    run("shl1", 6'b100001, 1, 6);
    check("shl1.z_lit", int'(z), 6'b000010);
    run("sar1", 6'b100001, 1, 8);
    check("sar1.z_lit", int'(z), 6'b110000);
    run("rol1", 6'b100001, 1, 9);
    check("rol1.z_lit", int'(z), 6'b000011);
    run("neg_min", 6'b100000, 0, 13);
    check("neg_min.sat_lit", int'(zNoRing), 31);
    check("neg_min.iof_lit", int'(IOF), 1);
    run("inc_wrap", 63, 0, 11);
    run("inc_ovf", 31, 0, 11);
    run("dec_zero", 0, 0, 12);
    run("dec_ovf", 32, 0, 12);
    run("sub_ovf", 31, 63, 1);

    for (int a = 0; a < 8; a++) begin
      run("shl_amt", 6'b101101, a, 6);
      run("shr_amt", 6'b101101, a, 7);
      run("sar_amt", 6'b101101, a, 8);
      run("rol_amt", 6'b101101, a, 9);
      run("ror_amt", 6'b101101, a, 10);
    end
    check("shr7.z_lit", int'(z) == 0 ? 0 : 1, 1);  // ROR by 7 of 101101 is nonzero

    for (int i = 0; i < 6; i++) begin
      run((i % 2 == 0) ? "b2b_and" : "b2b_or", 6'b101010, 6'b011100, (i % 2 == 0) ? 2 : 3);
      check("b2b.z_lit", int'(z), (i % 2 == 0) ? 6'b001000 : 6'b111110);
    end

    run("mul", 8, 8, 14);
`ifdef ALU_MUL_EN
    check("mul.sat_lit", int'(zNoRing), 31);
`else
    check("mul_off.zf_lit", int'(ZF), 1);
`endif
    run("pass", 0, 6'b010101, 15);
    run("not", 6'b010101, 0, 5);

    // Reset asserted while a result is in flight discards it.
    x = 6'd7; y = 6'd9; op = 4'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid_rst");
    rst = 1'b0;
    run("after_mid_rst", 7, 9, 0);

    for (int i = 0; i < 400; i++) begin
      run("rand", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
          int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 6-bit two's-complement ALU with registered result and flags; one-cycle latency.
- `z` is the ring (mod-64, wrap-around) result. `zNoRing` is the signed-saturated result, for consumers that must not wrap.
- Flags: `IOF` (signed overflow), `BAF` (unsigned carry/borrow or bit shifted out), `ZF` (zero).
- Sits in the datapath as the sole arithmetic/logic unit, fed by the register file and opcode decode.

Parameters:
- `W`, 6, datapath width. All ports scale with it; the Test Plan values assume 6.
- `OPW`, 4, opcode width (fixed at 4).

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `x`  in  W  operand A, two's complement
- `y`  in  W  operand B; shifts use only `y[2:0]`
- `op`  in  4  operation select
- `z`  out  W  registered wrapped result
- `zNoRing`  out  W  registered saturated result
- `IOF`  out  1  registered signed-overflow flag
- `BAF`  out  1  registered carry / borrow / shifted-out bit
- `ZF`  out  1  registered flag, 1 when the wrapped result is 0

Behaviour:
- Reset: on a rising `clk` with `rst`=1, `z`=0, `zNoRing`=0, `IOF`=0, `BAF`=0, `ZF`=0. Reset wins over any `op`.
- Latency: inputs are sampled every rising edge and outputs update on that edge. There is no handshake or enable, so a new op is accepted every cycle.
- Opcodes (`z` is always the result mod 2^W):
  - 0 ADD: x+y
  - 1 SUB: x-y
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~x
  - 6 SHL: x<<y[2:0]
  - 7 SHR: logical right shift
  - 8 SAR: arithmetic right shift
  - 9 ROL: rotate left by y[2:0] mod W
  - 10 ROR: rotate right by y[2:0] mod W
  - 11 INC: x+1
  - 12 DEC: x-1
  - 13 NEG: 0-x
  - 14 MUL (see Optional Feature)
  - 15 PASS: z=y
- `IOF`:
  - ADD/INC: operand signs equal and result sign differs.
  - SUB/DEC/NEG: operand signs differ and result sign differs from x (for NEG, the minuend is 0).
  - All other ops: 0.
- `BAF`:
  - ADD/INC: carry out of bit W-1.
  - SUB/DEC/NEG: borrow (unsigned minuend < subtrahend).
  - SHL: last bit shifted out of the MSB. SHR/SAR: last bit shifted out of the LSB.
  - Any shift by 0: BAF=0.
  - Logical ops, rotates, PASS: 0.
- `ZF`: 1 iff the wrapped `z` result is all zeros. It is computed on the wrapped result, never on `zNoRing`.
- `zNoRing`:
  - For ADD/SUB/INC/DEC/NEG/MUL with signed overflow: clamp to +31 (`011111`) on positive overflow, -32 (`100000`) on negative overflow.
  - Otherwise equal to `z`.
- Boundaries:
  - NEG of -32 gives `z`=-32, `IOF`=1, `zNoRing`=+31.
  - Shift amounts 6 and 7 on SHL/SHR give `z`=0. SAR by 6 or 7 gives all sign bits.
  - `rst` asserted mid-stream discards the in-flight result. The first post-reset result appears one edge after `rst` deasserts.

Optional Feature:
- Macro `ALU_MUL_EN`.
- Defined: op 14 = signed multiply.
  - `z` = low W bits of the 2W-bit product.
  - `IOF`=1 if the product does not fit in W signed bits; `zNoRing` is saturated accordingly.
  - `BAF`=1 if the unsigned product high W bits are nonzero.
  - Purely combinational, same one-cycle latency.
- Undefined: op 14 yields `z`=0, `zNoRing`=0, `IOF`=0, `BAF`=0, `ZF`=1. No multiplier is inferred.

Decomposition:
- Package `alu_pkg`:
  - enum `alu_op_e` (16 opcodes above)
  - localparams `ALU_W`=6, `ALU_OPW`=4
  - constants `SAT_MAX` / `SAT_MIN`
- One sub-module, `alu_shifter`: a combinational barrel unit for SHL/SHR/SAR/ROL/ROR that returns the result and the shifted-out bit.
- Arithmetic, saturation, flags and the output register stay in `alu`.

Test Plan:
- Reset: hold `rst`=1 with x=5, y=3, op=0 → all outputs 0; release `rst` → next edge `z`=8, `ZF`=0, `IOF`=0, `BAF`=0.
- ADD overflow: x=31, y=1, op=0 → `z`=`100000`, `zNoRing`=`011111`, `IOF`=1, `BAF`=0, `ZF`=0.
- SUB to zero / borrow:
  - x=0, y=0, op=1 → `z`=0, `ZF`=1, `BAF`=0.
  - x=0, y=1, op=1 → `z`=`111111`, `BAF`=1, `IOF`=0.
- Shifts:
  - x=`100001`, y=1, op=6 → `z`=`000010`, `BAF`=1.
  - op=8 same inputs → `z`=`110000`, `BAF`=1.
  - op=9 → `z`=`000011`, `BAF`=0.
- NEG corner: x=`100000`, op=13 → `z`=`100000`, `IOF`=1, `zNoRing`=`011111`.
- Back-to-back plus MUL:
  - Alternate op 2 and 3 every cycle with x=`101010`, y=`011100` → `z` alternates `001000`, `111110` one cycle later.
  - With `ALU_MUL_EN`: x=8, y=8, op=14 → `z`=0, `ZF`=1, `IOF`=1, `zNoRing`=`011111`.
